clkdiv_multi: RTL and testbench
===============================

# clkdiv_multi

Parametrised multi-channel clock divider producing, per channel, a registered divided clock and a one-cycle rising-edge tick (clock enable). The divisor is runtime-programmable through a valid/ready write port, and changes apply only at period boundaries, so no runt pulses are produced. A common sync input phase-aligns all channels. It sits between the board clock and the CPU, memory and IO clock domains, replacing the fixed single divider.

## Interface
- NUM_CH, 2: number of independent channels.
- CNT_W, 16: width of the divisor and the counters; the maximum divisor is 2^CNT_W-1.
- DEFAULT_DIV, 10000: divisor loaded into every channel at reset, in clk_in1 cycles per output period; must be >= 2.
- CH_W, max(1,$clog2(NUM_CH)): width of the channel select (derived).

Ports:
- clk_in1  in  1  board clock; sole clock of the block.
- rst  in  1  asynchronous, active-high reset.
- ch_en  in  NUM_CH  per-channel run enable.
- sync  in  1  one-cycle pulse that restarts all channels at phase 0.
- cfg_valid  in  1  divisor write request.
- cfg_ready  out  1  write can be accepted; equals ~pending[cfg_ch].
- cfg_ch  in  CH_W  target channel.
- cfg_div  in  CNT_W  new divisor.
- cfg_err  out  1  one-cycle pulse: the write was rejected (cfg_div < 2 or cfg_ch >= NUM_CH).
- clk_out  out  NUM_CH  registered divided clock per channel.
- tick  out  NUM_CH  one-cycle pulse per channel, coincident with the 0->1 transition of clk_out.

## Operation
- Per channel state: cnt (CNT_W bits), div (active divisor), pend_div, pending flag.
- Active divisor D gives L = floor(D/2) low cycles followed by H = D-L high cycles. D=10000 gives 5000/5000. D=5 gives 2 low, 3 high.
- Next-count rule: cnt_next = (cnt == D-1) ? 0 : cnt+1. The outputs are registered as clk_out <= (cnt_next >= L) and tick <= (cnt_next == L).
- Priority per channel: rst > ~ch_en > sync > count.
- ~ch_en: cnt, clk_out and tick are forced to 0. Any pending divisor is applied immediately. When the channel is re-enabled it restarts at phase 0.
- sync: every channel's cnt_next is 0, clk_out <= 0 and tick <= 0, and pending divisors are applied.
- Write handshake: a write is accepted when cfg_valid & cfg_ready at a clk_in1 edge.
  - Valid write: pend_div <= cfg_div and pending <= 1.
  - Invalid write: nothing is stored and cfg_err is pulsed the next cycle. cfg_ready is not lowered by an invalid write.
- Apply rule: at a wrap edge (cnt == D-1), if pending is set, div <= pend_div and pending <= 0. A write accepted on the same edge as a wrap is applied at the next wrap, not that one.
- While pending is set, further writes to that channel stall (cfg_ready = 0). Writes to other channels are unaffected.

## Timing
- Reset values: cnt = 0, div = DEFAULT_DIV, pending = 0, clk_out = 0, tick = 0, cfg_err = 0, so cfg_ready = 1.
- After rst falls with ch_en = 1, the L-th clk_in1 rising edge sets clk_out and tick. tick then repeats every D edges.
- Latency:
  - cfg_err: 1 cycle after the rejected write.
  - Divisor change: takes effect on the first period that starts after the next wrap.
- A mid-cycle rst or ch_en deassert may truncate a high phase. This is an accepted consequence of the enable; divisor changes never truncate a phase.
- All outputs are registered; there is no combinational path from inputs to clk_out or tick.

## Structure
- clkdiv_pkg holds:
  - MIN_DIV = 2;
  - the default CNT_W;
  - typedef div_t (logic [CNT_W-1:0]);
  - a helper function for the low-phase length (D >> 1).
- Sub-module clkdiv_channel contains one channel's counter, divisor/pending registers and output registers. The top instantiates NUM_CH copies and owns the cfg decode, cfg_ready mux and cfg_err register.

## Test plan
- NUM_CH=2, DEFAULT_DIV=4, ch_en=2'b11 after reset -> each clk_out is 0,0,1,1 repeating and tick is high every 4th cycle, starting at the 2nd edge.
- Write ch0 div=5 at cnt=1 -> the current period completes as 4, then 2 low / 3 high. cfg_ready is low from the accept edge until the wrap edge. ch1 is unchanged.
- Write div=1, then cfg_ch=3 with NUM_CH=2 -> each write gives a cfg_err pulse 1 cycle later, div stays 4, and cfg_ready stays 1.
- Write ch0 div=6 exactly on a wrap edge, then immediately attempt a second write -> the second write stalls. The first write applies one full period of 4 later.
- Offset the channels with ch_en[1]=0 for 1 cycle, then pulse sync -> both clk_out go 0 next cycle and both tick on the same edge 2 cycles later.
- Assert rst mid high-phase with a write pending -> all outputs are 0 asynchronously, the pending write is discarded, and div returns to DEFAULT_DIV on release.

Source files
------------

// File: rtl/clkdiv_pkg.sv
// Shared constants, types and helpers for the multi-channel clock divider.
package clkdiv_pkg;

  localparam int unsigned MIN_DIV   = 2;
  localparam int unsigned DEF_CNT_W = 16;

  typedef logic [DEF_CNT_W-1:0] div_t;

  // Low-phase length of a period of d cycles; the high phase takes the odd cycle.
  function automatic logic [31:0] low_len(input logic [31:0] d);
    return d >> 1;
  endfunction

endpackage

// File: rtl/clkdiv_multi_if.sv
// Divisor write port: valid/ready request with a registered reject pulse.
interface clkdiv_multi_if
  import clkdiv_pkg::*;
#(
  parameter int unsigned CH_W  = 1,
  parameter int unsigned CNT_W = DEF_CNT_W
);

  logic             valid;
  logic             ready;
  logic [CH_W-1:0]  ch;
  logic [CNT_W-1:0] div;
  logic             err;

  modport master (output valid, ch, div, input ready, err);
  modport slave  (input valid, ch, div, output ready, err);

endinterface

// File: rtl/clkdiv_channel.sv
// One divider channel: phase counter, active/pending divisor and registered outputs.
module clkdiv_channel
  import clkdiv_pkg::*;
#(
  parameter int unsigned CNT_W       = DEF_CNT_W,
  parameter int unsigned DEFAULT_DIV = 10000
) (
  input  logic             clk_i,
  input  logic             rst,
  input  logic             en_i,
  input  logic             sync_i,
  input  logic             wr_i,
  input  logic [CNT_W-1:0] wr_div_i,
  output logic             clk_o,
  output logic             tick_o,
  output logic             pending_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] pend_div_q, pend_div_d;
  logic             pending_q, pending_d;
  logic             clk_d, tick_d;
  logic [CNT_W-1:0] low;
  logic             wrap;

  assign low  = CNT_W'(low_len(32'(div_q)));
  assign wrap = (cnt_q == div_q - CNT_W'(1));

  always_comb begin
    cnt_d      = cnt_q;
    div_d      = div_q;
    pend_div_d = pend_div_q;
    pending_d  = pending_q;
    clk_d      = 1'b0;
    tick_d     = 1'b0;
    if (!en_i || sync_i) begin
      // Idle or restart: the next period starts fresh, so a pending divisor can land now.
      cnt_d = '0;
      if (pending_q) begin
        div_d     = pend_div_q;
        pending_d = 1'b0;
      end
    end else begin
      cnt_d  = wrap ? '0 : cnt_q + CNT_W'(1);
      clk_d  = (cnt_d >= low);
      tick_d = (cnt_d == low);
      if (wrap && pending_q) begin
        div_d     = pend_div_q;
        pending_d = 1'b0;
      end
    end
    // Writes are only accepted with pending clear, so they never collide with an apply.
    if (wr_i) begin
      pend_div_d = wr_div_i;
      pending_d  = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      div_q      <= CNT_W'(DEFAULT_DIV);
      pend_div_q <= '0;
      pending_q  <= 1'b0;
      clk_o      <= 1'b0;
      tick_o     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      pend_div_q <= pend_div_d;
      pending_q  <= pending_d;
      clk_o      <= clk_d;
      tick_o     <= tick_d;
    end
  end

  assign pending_o = pending_q;

endmodule

// File: rtl/clkdiv_multi.sv
// Multi-channel programmable clock divider with glitch-free divisor updates and common sync.
module clkdiv_multi
  import clkdiv_pkg::*;
#(
  parameter int unsigned NUM_CH      = 2,
  parameter int unsigned CNT_W       = DEF_CNT_W,
  parameter int unsigned DEFAULT_DIV = 10000,
  parameter int unsigned CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_in1,
  input  logic              rst,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              sync,
  clkdiv_multi_if.slave     cfg,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick
);

  logic [NUM_CH-1:0] pending;
  logic [NUM_CH-1:0] wr;
  logic              ready;
  logic              ch_ok, div_ok, accept;
  logic              cfg_err_q;

  // Out-of-range channels report ready so the reject can complete.
  always_comb begin
    ready = 1'b1;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (cfg.ch == CH_W'(i)) ready = ~pending[i];
    end
  end

  assign ch_ok     = (32'(cfg.ch) < NUM_CH);
  assign div_ok    = (cfg.div >= CNT_W'(MIN_DIV));
  assign accept    = cfg.valid & ready;
  assign cfg.ready = ready;
  assign cfg.err   = cfg_err_q;

  always_ff @(posedge clk_in1 or posedge rst) begin
    if (rst) cfg_err_q <= 1'b0;
    else     cfg_err_q <= accept & ~(ch_ok & div_ok);
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : gen_ch
    assign wr[g] = accept & ch_ok & div_ok & (cfg.ch == CH_W'(g));

    clkdiv_channel #(
      .CNT_W      (CNT_W),
      .DEFAULT_DIV(DEFAULT_DIV)
    ) u_channel (
      .clk_i    (clk_in1),
      .rst      (rst),
      .en_i     (ch_en[g]),
      .sync_i   (sync),
      .wr_i     (wr[g]),
      .wr_div_i (cfg.div),
      .clk_o    (clk_out[g]),
      .tick_o   (tick[g]),
      .pending_o(pending[g])
    );
  end

endmodule

// File: tb/tb_clkdiv_multi.sv
// Table-driven bench for clkdiv_multi with a scoreboard queue for the cfg_err pulse.
module tb_clkdiv_multi;

  localparam int unsigned NumCh  = 2;
  localparam int unsigned CntW   = 16;
  localparam int unsigned DefDiv = 4;
  localparam int unsigned ChW    = 2;

  logic              clk_in1 = 1'b0;
  logic              rst     = 1'b1;
  logic [NumCh-1:0]  ch_en;
  logic              sync;
  logic [NumCh-1:0]  clk_out;
  logic [NumCh-1:0]  tick;

  clkdiv_multi_if #(.CH_W(ChW), .CNT_W(CntW)) cfg ();

  clkdiv_multi #(
    .NUM_CH     (NumCh),
    .CNT_W      (CntW),
    .DEFAULT_DIV(DefDiv),
    .CH_W       (ChW)
  ) dut (
    .clk_in1(clk_in1),
    .rst    (rst),
    .ch_en  (ch_en),
    .sync   (sync),
    .cfg    (cfg),
    .clk_out(clk_out),
    .tick   (tick)
  );

  always #5 clk_in1 = ~clk_in1;

  // rdy: cfg_ready before the edge; clk/tick: outputs after the edge.
  typedef struct {
    logic [1:0]  en;
    logic        sync;
    logic        valid;
    logic [1:0]  ch;
    logic [15:0] div;
    logic        rdy;
    logic [1:0]  clk;
    logic [1:0]  tick;
  } vec_t;

  vec_t vecs[$];
  logic exp_err_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(input logic [1:0] en, input logic s, input logic va,
                              input logic [1:0] ch, input logic [15:0] d, input logic r,
                              input logic [1:0] c, input logic [1:0] t);
    vec_t v;
    v.en = en; v.sync = s; v.valid = va; v.ch = ch; v.div = d;
    v.rdy = r; v.clk = c; v.tick = t;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic run_row(input int idx, input vec_t v);
    logic e;
    ch_en     = v.en;
    sync      = v.sync;
    cfg.valid = v.valid;
    cfg.ch    = v.ch;
    cfg.div   = v.div;
    #2;
    check($sformatf("row%0d ready", idx), 32'(cfg.ready), 32'(v.rdy));
    exp_err_q.push_back(v.valid && v.rdy && (v.div < 16'd2 || v.ch >= 2'd2));
    @(posedge clk_in1);
    #1;
    check($sformatf("row%0d clk_out", idx), 32'(clk_out), 32'(v.clk));
    check($sformatf("row%0d tick", idx), 32'(tick), 32'(v.tick));
    if (exp_err_q.size() == 0) begin
      check($sformatf("row%0d err queue empty", idx), 32'd1, 32'd0);
    end else begin
      e = exp_err_q.pop_front();
      check($sformatf("row%0d cfg_err", idx), 32'(cfg.err), 32'(e));
    end
  endtask

  initial begin
    // Free-run from reset, D=4: 2 low / 2 high.
    vecs.push_back(mk(2'b11, 0, 0, 0, 0, 1, 2'b00, 2'b00));
    vecs.push_back(mk(2'b11, 0, 0, 0, 0, 1, 2'b11, 2'b11));
    vecs.push_back(mk(2'b11, 0, 0, 0, 0, 1, 2'b11, 2'b00));
    vecs.push_back(mk(2'b11, 0, 0, 0, 0, 1, 2'b00, 2'b00));
    vecs.push_back(mk(2'b11, 0, 0, 0, 0, 1, 2'b00, 2'b00));
    vecs.push_back(mk(2'b11, 0, 0, 0, 0, 1, 2'b11, 2'b11));
    vecs.push_back(mk(2'b11, 0, 0, 0, 0, 1, 2'b11, 2'b00));
    vecs.push_back(mk(2'b11, 0, 0, 0, 0, 1, 2'b00, 2'b00));
    // Offset ch1 by one cycle, then realign with sync.
    vecs.push_back(mk(2'b01, 0, 0, 0, 0, 1, 2'b00, 2'b00));
    vecs.push_back(mk(2'b11, 0, 0, 0, 0, 1, 2'b01, 2'b01));
    vecs.push_back(mk(2'b11, 0, 0, 0, 0, 1, 2'b11, 2'b10));
    vecs.push_back(mk(2'b11, 1, 0, 0, 0, 1, 2'b00, 2'b00));
    vecs.push_back(mk(2'b11, 0, 0, 0, 0, 1, 2'b00, 2'b00));
    vecs.push_back(mk(2'b11, 0, 0, 0, 0, 1, 2'b11, 2'b11));
    vecs.push_back(mk(2'b11, 0, 0, 0, 0, 1, 2'b11, 2'b00));
    vecs.push_back(mk(2'b11, 0, 0, 0, 0, 1, 2'b00, 2'b00));
    // ch0 div=5 written at cnt=1: finishes the period of 4, then 2 low / 3 high.
    vecs.push_back(mk(2'b11, 0, 0, 0, 0, 1, 2'b00, 2'b00));
    vecs.push_back(mk(2'b11, 0, 1, 0, 5, 1, 2'b11, 2'b11));
    vecs.push_back(mk(2'b11, 0, 0, 0, 0, 0, 2'b11, 2'b00));
    vecs.push_back(mk(2'b11, 0, 0, 0, 0, 0, 2'b00, 2'b00));
    vecs.push_back(mk(2'b11, 0, 0, 0, 0, 1, 2'b00, 2'b00));
    vecs.push_back(mk(2'b11, 0, 0, 0, 0, 1, 2'b11, 2'b11));
    vecs.push_back(mk(2'b11, 0, 0, 0, 0, 1, 2'b11, 2'b00));
    vecs.push_back(mk(2'b11, 0, 0, 0, 0, 1, 2'b01, 2'b00));
    vecs.push_back(mk(2'b11, 0, 0, 0, 0, 1, 2'b00, 2'b00));
    // Rejected writes: div=1, then channel 3; ready stays high, divisor unchanged.
    vecs.push_back(mk(2'b11, 0, 1, 0, 1, 1, 2'b10, 2'b10));
    vecs.push_back(mk(2'b11, 0, 1, 3, 7, 1, 2'b11, 2'b01));
    vecs.push_back(mk(2'b11, 0, 0, 0, 0, 1, 2'b01, 2'b00));
    vecs.push_back(mk(2'b11, 0, 0, 0, 0, 1, 2'b01, 2'b00));
    vecs.push_back(mk(2'b11, 0, 0, 0, 0, 1, 2'b10, 2'b10));
    vecs.push_back(mk(2'b11, 0, 0, 0, 0, 1, 2'b10, 2'b00));
    vecs.push_back(mk(2'b11, 0, 0, 0, 0, 1, 2'b01, 2'b01));
    vecs.push_back(mk(2'b11, 0, 0, 0, 0, 1, 2'b01, 2'b00));
    vecs.push_back(mk(2'b11, 0, 0, 0, 0, 1, 2'b11, 2'b10));
    // ch0 div=6 on its wrap edge; second write stalls; ch1 write still accepted.
    vecs.push_back(mk(2'b11, 0, 1, 0, 6, 1, 2'b10, 2'b00));
    vecs.push_back(mk(2'b11, 0, 1, 0, 7, 0, 2'b00, 2'b00));
    vecs.push_back(mk(2'b11, 0, 1, 0, 7, 0, 2'b01, 2'b01));
    vecs.push_back(mk(2'b11, 0, 1, 1, 4, 1, 2'b11, 2'b10));
    vecs.push_back(mk(2'b11, 0, 0, 0, 0, 0, 2'b11, 2'b00));
    vecs.push_back(mk(2'b11, 0, 0, 0, 0, 0, 2'b00, 2'b00));
    vecs.push_back(mk(2'b11, 0, 0, 0, 0, 1, 2'b00, 2'b00));
    vecs.push_back(mk(2'b11, 0, 0, 0, 0, 1, 2'b10, 2'b10));
    vecs.push_back(mk(2'b11, 0, 0, 0, 0, 1, 2'b11, 2'b01));
    vecs.push_back(mk(2'b11, 0, 0, 0, 0, 1, 2'b01, 2'b00));
    vecs.push_back(mk(2'b11, 0, 0, 0, 0, 1, 2'b01, 2'b00));
    vecs.push_back(mk(2'b11, 0, 0, 0, 0, 1, 2'b10, 2'b10));
    // Leave a ch0 write pending and stop in ch0's high phase.
    vecs.push_back(mk(2'b11, 0, 1, 0, 9, 1, 2'b10, 2'b00));
    vecs.push_back(mk(2'b11, 0, 0, 0, 0, 0, 2'b00, 2'b00));
    vecs.push_back(mk(2'b11, 0, 0, 0, 0, 0, 2'b01, 2'b01));

    ch_en = '0; sync = 1'b0;
    cfg.valid = 1'b0; cfg.ch = '0; cfg.div = '0;
    repeat (2) @(posedge clk_in1);
    #1;
    check("reset clk_out", 32'(clk_out), 32'd0);
    check("reset tick", 32'(tick), 32'd0);
    check("reset cfg_err", 32'(cfg.err), 32'd0);
    check("reset cfg_ready", 32'(cfg.ready), 32'd1);
    rst = 1'b0;

    foreach (vecs[i]) run_row(i, vecs[i]);

    // Asynchronous reset in the middle of ch0's high phase with a write pending.
    cfg.valid = 1'b0;
    cfg.ch    = '0;
    #2;
    rst = 1'b1;
    #1;
    check("async rst clk_out", 32'(clk_out), 32'd0);
    check("async rst tick", 32'(tick), 32'd0);
    check("async rst cfg_ready", 32'(cfg.ready), 32'd1);
    check("async rst cfg_err", 32'(cfg.err), 32'd0);
    @(posedge clk_in1);
    #1;
    rst = 1'b0;
    // Both channels must be back on the default divisor of 4.
    for (int i = 0; i < 8; i++) run_row(100 + i, vecs[i]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
